// File: rtl/charlieplex_scan.sv
// Wishbone-controlled row-by-row PWM scanner for a 7-pin, 42-LED charlieplexed matrix.
// Define CHARLIEPLEX_DOUBLE_BUFFER_EN for front/back pixel buffers with a frame-synchronous swap.
module charlieplex_scan #(
  parameter int TICKS_PER_SLOT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [5:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic [6:0] charlieplex_o,
  output logic [6:0] charlieplex_oe
);
  localparam int TW = $clog2(TICKS_PER_SLOT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SLOT - 1);
  localparam int NPIX = 42;
  localparam logic [5:0] ADR_CTRL = 6'd42;
  localparam logic [5:0] ADR_FRAME = 6'd43;

  logic          ack_q, ack_d;
  logic [7:0]    dat_q, dat_d;
  logic [5:0]    req_adr_q, req_adr_d;
  logic [3:0]    req_dat_q, req_dat_d;
  logic          req_we_q, req_we_d;
  logic          enable_q, enable_d;
  logic [7:0]    frame_q, frame_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    slot_q, slot_d;
  logic [2:0]    row_q, row_d;
  logic [23:0]   latch_q, latch_d;
  logic [6:0]    pin_o_q, pin_o_d, pin_oe_q, pin_oe_d;
  logic [3:0]    back_q [NPIX];
  logic [3:0]    back_d [NPIX];
  logic [3:0]    disp_d [NPIX];
  logic          commit, tick_wrap, slot_wrap, row_wrap;
  logic [7:0]    rd_data;
  logic          unused_bits;

  assign unused_bits = ^wb_dat_i[7:4];

`ifdef CHARLIEPLEX_DOUBLE_BUFFER_EN
  logic [3:0] front_q [NPIX];
  logic [3:0] front_d [NPIX];
  logic       swap_q, swap_d;

  // The new back buffer keeps its contents, which equal the frame just promoted to the front.
  always_comb begin
    swap_d  = swap_q;
    front_d = front_q;
    if (swap_q && (!enable_q || (enable_d && row_wrap))) begin
      swap_d  = 1'b0;
      front_d = back_q;
    end
    if (commit && req_adr_q == ADR_CTRL && req_dat_q[1]) swap_d = 1'b1;
    disp_d = front_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_q <= 1'b0;
      for (int i = 0; i < NPIX; i++) front_q[i] <= '0;
    end else begin
      swap_q  <= swap_d;
      front_q <= front_d;
    end
  end
`else
  logic swap_q;
  assign swap_q = 1'b0;
  always_comb disp_d = back_d;
`endif

  // Requests are captured on the strobe so the write can commit at the end of the ack cycle.
  always_comb begin
    commit    = ack_q & req_we_q;
    ack_d     = wb_cyc_i & wb_stb_i & ~ack_q;
    req_adr_d = req_adr_q;
    req_dat_d = req_dat_q;
    req_we_d  = req_we_q;
    if (ack_d) begin
      req_adr_d = wb_adr_i;
      req_dat_d = wb_dat_i[3:0];
      req_we_d  = wb_we_i;
    end
    rd_data = 8'h00;
    if (wb_adr_i < 6'(NPIX)) rd_data = {4'h0, back_q[wb_adr_i]};
    else if (wb_adr_i == ADR_CTRL) rd_data = {6'h00, swap_q, enable_q};
    else if (wb_adr_i == ADR_FRAME) rd_data = frame_q;
    dat_d = ack_d ? rd_data : 8'h00;
    enable_d = enable_q;
    if (commit && req_adr_q == ADR_CTRL) enable_d = req_dat_q[0];
    back_d = back_q;
    if (commit && req_adr_q < 6'(NPIX)) back_d[req_adr_q] = req_dat_q;
  end

  always_comb begin
    tick_wrap = (tick_q == TICK_LAST);
    slot_wrap = tick_wrap && (slot_q == 4'd15);
    row_wrap  = slot_wrap && (row_q == 3'd6);
    tick_d    = '0;
    slot_d    = '0;
    row_d     = '0;
    frame_d   = frame_q;
    if (enable_d) begin
      tick_d = tick_wrap ? '0 : tick_q + TW'(1);
      slot_d = tick_wrap ? slot_q + 4'd1 : slot_q;
      row_d  = slot_wrap ? (row_wrap ? 3'd0 : row_q + 3'd1) : row_q;
      if (row_wrap) frame_d = frame_q + 8'd1;
    end
  end

  // Brightness for the six column pins of the active row is refreshed only at slot boundaries.
  always_comb begin
    latch_d = latch_q;
    if (!enable_d || tick_wrap) begin
      for (int k = 0; k < 6; k++) latch_d[5'(k * 4) +: 4] = disp_d[6'(int'(row_d) * 6 + k)];
    end
    pin_o_d  = '0;
    pin_oe_d = '0;
    if (enable_d && slot_q != 4'd15) begin
      pin_o_d[row_q]  = 1'b1;
      pin_oe_d[row_q] = 1'b1;
      for (int p = 0; p < 7; p++) begin
        if (p != int'(row_q)) begin
          if (latch_q[5'(((p < int'(row_q)) ? p : p - 1) * 4) +: 4] > slot_q) pin_oe_d[3'(p)] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      req_adr_q <= '0;
      req_dat_q <= '0;
      req_we_q  <= 1'b0;
      enable_q  <= 1'b0;
      frame_q   <= '0;
      tick_q    <= '0;
      slot_q    <= '0;
      row_q     <= '0;
      latch_q   <= '0;
      pin_o_q   <= '0;
      pin_oe_q  <= '0;
      for (int i = 0; i < NPIX; i++) back_q[i] <= '0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      req_adr_q <= req_adr_d;
      req_dat_q <= req_dat_d;
      req_we_q  <= req_we_d;
      enable_q  <= enable_d;
      frame_q   <= frame_d;
      tick_q    <= tick_d;
      slot_q    <= slot_d;
      row_q     <= row_d;
      latch_q   <= latch_d;
      pin_o_q   <= pin_o_d;
      pin_oe_q  <= pin_oe_d;
      back_q    <= back_d;
    end
  end

  assign wb_ack_o       = ack_q;
  assign wb_dat_o       = dat_q;
  assign charlieplex_o  = pin_o_q;
  assign charlieplex_oe = pin_oe_q;
endmodule

// File: tb/tb_charlieplex_scan.sv
// Scoreboard bench for charlieplex_scan: bus reads and per-cycle pin levels are predicted
// from a frame/slot arithmetic model and checked by a monitor on the falling clock edge.
module tb_charlieplex_scan;
  localparam int T = 2;
  localparam int FRAME_CYC = 112 * T;
  localparam int NPIX = 42;

  typedef struct {
    bit         is_read;
    logic [7:0] exp;
    string      name;
  } bus_op_t;

  logic       clk;
  logic       rst;
  logic       wb_cyc_i, wb_stb_i, wb_we_i;
  logic [5:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic [6:0] charlieplex_o, charlieplex_oe;

  bus_op_t     bus_q[$];
  logic [13:0] pin_q[$];
  int          total = 0;
  int          bad = 0;
  int          neg_count = 0;
  logic [3:0]  back_model [NPIX];
  logic [3:0]  front_model [NPIX];
  bit          en_model;
  int          frame_model;
  int          en_start;
  bit          swap_pend;
  int          swap_k;

  charlieplex_scan #(.TICKS_PER_SLOT(T)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .charlieplex_o(charlieplex_o), .charlieplex_oe(charlieplex_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) neg_count++;

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Pins for the n-th enabled cycle, straight from the row/slot/brightness rules.
  function automatic logic [13:0] expectPins(input int n);
    int row, slot, k;
    logic [6:0] o, oe;
    logic [3:0] b;
    row  = (n / (16 * T)) % 7;
    slot = (n / T) % 16;
    o    = '0;
    oe   = '0;
    if (slot != 15) begin
      o[row]  = 1'b1;
      oe[row] = 1'b1;
      for (int p = 0; p < 7; p++) begin
        if (p != row) begin
          k = (p < row) ? p : p - 1;
          b = (swap_pend && (n / FRAME_CYC) >= swap_k) ? back_model[row * 6 + k] : front_model[row * 6 + k];
          if (int'(b) > slot) oe[p] = 1'b1;
        end
      end
    end
    return {oe, o};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_ack_o) begin
        if (bus_q.size() == 0) checkOutput("stray-ack", 16'(wb_ack_o), 16'd0);
        else begin
          bus_op_t op;
          op = bus_q.pop_front();
          if (op.is_read) checkOutput(op.name, {8'h00, wb_dat_o}, {8'h00, op.exp});
        end
      end
      if (pin_q.size() > 0) begin
        logic [13:0] e;
        e = pin_q.pop_front();
        checkOutput("pins{oe,o}", {2'b00, charlieplex_oe, charlieplex_o}, {2'b00, e});
      end
    end
  end

  task automatic applyStimulus(input bit we, input logic [5:0] adr, input logic [7:0] dat,
                               input logic [7:0] exp_rd, input string name, input int pin_cycles);
    bus_op_t op;
    bit got_ack;
    int n_now;
    op.is_read = !we;
    op.exp     = exp_rd;
    op.name    = name;
    bus_q.push_back(op);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    got_ack = 1'b0;
    for (int i = 0; i < 16 && !got_ack; i++) begin
      @(negedge clk);
      got_ack = wb_ack_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got_ack) begin
      bus_q.delete(bus_q.size() - 1);
      checkOutput({name, "-ack"}, 16'(got_ack), 16'd1);
      return;
    end
    @(posedge clk);
    n_now = neg_count - en_start;
    if (we) begin
      if (adr < 6'd42) begin
        back_model[adr] = dat[3:0];
`ifndef CHARLIEPLEX_DOUBLE_BUFFER_EN
        front_model[adr] = dat[3:0];
`endif
      end else if (adr == 6'd42) begin
`ifdef CHARLIEPLEX_DOUBLE_BUFFER_EN
        if (dat[1]) begin
          swap_pend = 1'b1;
          swap_k = (n_now + 2 + FRAME_CYC - 1) / FRAME_CYC;
        end
`endif
        if (en_model && !dat[0]) frame_model += n_now / FRAME_CYC;
        if (!en_model && dat[0]) begin
          en_start = neg_count;
          n_now = 0;
        end
        en_model = dat[0];
      end
    end
    for (int i = 0; i < pin_cycles; i++) pin_q.push_back(en_model ? expectPins(n_now + i) : 14'h0);
  endtask

  task automatic drain_pins();
    int w;
    w = 0;
    while (pin_q.size() > 0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (pin_q.size() > 0) begin
      checkOutput("pin-drain", 16'(pin_q.size()), 16'd0);
      pin_q.delete();
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < NPIX; i++) begin
      back_model[i]  = 4'h0;
      front_model[i] = 4'h0;
    end
    en_model = 1'b0; frame_model = 0; en_start = 0; swap_pend = 1'b0; swap_k = 0;
  endtask

  initial begin
    logic [3:0] pat [NPIX];
    bus_op_t op;
    int acks, a;
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
    reset_models();
    repeat (3) @(negedge clk);
    checkOutput("reset-oe", {9'h0, charlieplex_oe}, 16'h0);
    checkOutput("reset-o", {9'h0, charlieplex_o}, 16'h0);
    checkOutput("reset-ack", {15'h0, wb_ack_o}, 16'h0);
    checkOutput("reset-dat", {8'h0, wb_dat_o}, 16'h0);
    rst = 1'b0;

    applyStimulus(1'b0, 6'd42, 8'h00, 8'h00, "ctrl-rd", 0);
    applyStimulus(1'b0, 6'd43, 8'h00, 8'h00, "frame-rd", 0);
    applyStimulus(1'b1, 6'd5, 8'hF3, 8'h00, "pix5-wr", 0);
    applyStimulus(1'b0, 6'd5, 8'h00, 8'h03, "pix5-rd", 0);
    applyStimulus(1'b1, 6'd50, 8'hFF, 8'h00, "adr50-wr", 0);
    applyStimulus(1'b0, 6'd50, 8'h00, 8'h00, "adr50-rd", 0);

    // A held strobe must produce an ack every other cycle.
    op.is_read = 1'b1; op.exp = 8'h00; op.name = "adr50-held-rd";
    repeat (3) bus_q.push_back(op);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 6'd50;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checkOutput("held-acks", 16'(acks), 16'd3);
    repeat (2) @(negedge clk);
    if (bus_q.size() > 0) begin
      checkOutput("held-leftover", 16'(bus_q.size()), 16'd0);
      bus_q.delete();
    end

`ifndef CHARLIEPLEX_DOUBLE_BUFFER_EN
    applyStimulus(1'b1, 6'd42, 8'h02, 8'h00, "ctrl-swap-wr", 0);
    applyStimulus(1'b0, 6'd42, 8'h00, 8'h00, "ctrl-noswap-rd", 0);
`endif

    // Patterns: single full-brightness LED, half-brightness LED, then random frames.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NPIX; i++) pat[i] = (it >= 2) ? 4'($urandom_range(0, 15)) : 4'd0;
      if (it == 0) pat[0] = 4'd15;
      if (it == 1) pat[8] = 4'd8;
      for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, 6'(i), {4'($urandom), pat[i]}, 8'h00, "pix-wr", 0);
      repeat (4) begin
        a = $urandom_range(0, NPIX - 1);
        applyStimulus(1'b0, 6'(a), 8'h00, {4'h0, back_model[a]}, "pix-rd", 0);
      end
      applyStimulus(1'b1, 6'd42, 8'h01, 8'h00, "en-wr", FRAME_CYC + 8);
      drain_pins();
      applyStimulus(1'b1, 6'd42, 8'h00, 8'h00, "dis-wr", 4);
      drain_pins();
      applyStimulus(1'b0, 6'd43, 8'h00, 8'(frame_model), "frame-rd", 0);
    end

    // Asynchronous reset in the middle of an enabled scan.
    applyStimulus(1'b1, 6'd42, 8'h01, 8'h00, "en-wr", 0);
    repeat (37) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async-rst-oe", {9'h0, charlieplex_oe}, 16'h0);
    checkOutput("async-rst-o", {9'h0, charlieplex_o}, 16'h0);
    reset_models();
    @(negedge clk);
    checkOutput("async-rst-ack", {15'h0, wb_ack_o}, 16'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 6'd42, 8'h00, 8'h00, "ctrl-after-rst", 0);
    applyStimulus(1'b0, 6'd43, 8'h00, 8'h00, "frame-after-rst", 0);

    // FRAME counts to 0xFF and then wraps to 0x00.
    applyStimulus(1'b1, 6'd42, 8'h01, 8'h00, "en-wr", 0);
    repeat (255 * FRAME_CYC + 8) @(negedge clk);
    applyStimulus(1'b1, 6'd42, 8'h00, 8'h00, "dis-wr", 0);
    applyStimulus(1'b0, 6'd43, 8'h00, 8'(frame_model), "frame-ff-rd", 0);
    applyStimulus(1'b1, 6'd42, 8'h01, 8'h00, "en-wr", 0);
    repeat (FRAME_CYC + 8) @(negedge clk);
    applyStimulus(1'b1, 6'd42, 8'h00, 8'h00, "dis-wr", 4);
    drain_pins();
    applyStimulus(1'b0, 6'd43, 8'h00, 8'(frame_model), "frame-wrap-rd", 0);

`ifdef CHARLIEPLEX_DOUBLE_BUFFER_EN
    applyStimulus(1'b1, 6'd42, 8'h01, 8'h00, "en-wr", 0);
    applyStimulus(1'b1, 6'd0, 8'h0F, 8'h00, "pix0-back-wr", 0);
    applyStimulus(1'b1, 6'd42, 8'h03, 8'h00, "ctrl-swap-wr", 2 * FRAME_CYC);
    applyStimulus(1'b0, 6'd42, 8'h00, 8'h03, "ctrl-pending-rd", 0);
    drain_pins();
    for (int i = 0; i < NPIX; i++) front_model[i] = back_model[i];
    swap_pend = 1'b0;
    applyStimulus(1'b0, 6'd42, 8'h00, 8'h01, "ctrl-swapped-rd", 0);
    applyStimulus(1'b0, 6'd0, 8'h00, 8'h0F, "pix0-back-rd", 0);
    applyStimulus(1'b1, 6'd42, 8'h00, 8'h00, "dis-wr", 4);
    drain_pins();
`endif

    repeat (2) @(negedge clk);
    if (bus_q.size() > 0) checkOutput("bus-leftover", 16'(bus_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
